// File: rtl/capture_pkg.sv
// Shared types and helpers for the edge-triggered capture register bank.
// Holds the capture mode encoding and the per-channel event decode.
package capture_pkg;

    localparam int CAP_MODE_W = 2;

    typedef enum logic [1:0] {
        CAP_RISE  = 2'b00,
        CAP_FALL  = 2'b01,
        CAP_BOTH  = 2'b10,
        CAP_LEVEL = 2'b11
    } cap_mode_t;

    // Decide whether this cycle is a capture event for one channel.
    function automatic logic capEvent(
        input cap_mode_t mode,
        input logic      en,
        input logic      enPrev
    );
        logic hit;
        hit = 1'b0;
        unique case (mode)
            CAP_RISE:  hit = en & ~enPrev;
            CAP_FALL:  hit = ~en & enPrev;
            CAP_BOTH:  hit = en ^ enPrev;
            CAP_LEVEL: hit = en;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/capture_chan.sv
// One capture channel: enable history, held data word, valid and sticky overrun.
// validNext is exported so the bank can register an aligned any-valid summary.
module capture_chan
    import capture_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic [DATA_W-1:0]     iData,
    input  logic                  iEn,
    input  logic [CAP_MODE_W-1:0] iMode,
    input  logic                  iAck,
    input  logic                  iClrOvr,
    output logic [DATA_W-1:0]     oData,
    output logic                  oValid,
    output logic                  oOverrun,
    output logic                  validNext
);

    logic              enPrev;
    logic              hit;
    logic              ovrSet;
    logic [DATA_W-1:0] dataNext;
    logic              ovrNext;

    assign hit = capEvent(cap_mode_t'(iMode), iEn, enPrev);

    // An event over an unacknowledged word is lost data; an ack on
    // the same cycle means the consumer took it, so no overrun.
    assign ovrSet = hit & oValid & ~iAck;

    always_comb begin
        dataNext  = oData;
        validNext = oValid;
        ovrNext   = oOverrun;
        if (iReset) begin
            dataNext  = '0;
            validNext = 1'b0;
            ovrNext   = 1'b0;
        end else begin
            if (hit) begin
                dataNext  = iData;
                validNext = 1'b1;
            end else if (iAck) begin
                validNext = 1'b0;
            end
            if (ovrSet) begin
                ovrNext = 1'b1;
            end else if (iClrOvr) begin
                ovrNext = 1'b0;
            end
        end
    end

    // enPrev tracks iEn even in reset so a held enable gives no edge.
    always_ff @(posedge iClock) begin
        enPrev   <= iEn;
        oData    <= dataNext;
        oValid   <= validNext;
        oOverrun <= ovrNext;
    end

endmodule

// File: rtl/capture_latch_bank.sv
// Bank of independent edge-triggered capture channels with valid/overrun flags.
// All outputs are registered; oAnyValid is aligned with oValid.
module capture_latch_bank
    import capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
) (
    input  logic                         iClock,
    input  logic                         iReset,
    input  logic [NUM_CH*DATA_W-1:0]     iData,
    input  logic [NUM_CH-1:0]            iEn,
    input  logic [NUM_CH*CAP_MODE_W-1:0] iMode,
    input  logic [NUM_CH-1:0]            iAck,
    input  logic [NUM_CH-1:0]            iClrOvr,
    output logic [NUM_CH*DATA_W-1:0]     oData,
    output logic [NUM_CH-1:0]            oValid,
    output logic [NUM_CH-1:0]            oOverrun,
    output logic                         oAnyValid
);

    logic [NUM_CH-1:0] validNext;

    for (genvar c = 0; c < NUM_CH; c++) begin : gChan
        capture_chan #(
            .DATA_W(DATA_W)
        ) uChan (
            .iClock   (iClock),
            .iReset   (iReset),
            .iData    (iData[c*DATA_W +: DATA_W]),
            .iEn      (iEn[c]),
            .iMode    (iMode[c*CAP_MODE_W +: CAP_MODE_W]),
            .iAck     (iAck[c]),
            .iClrOvr  (iClrOvr[c]),
            .oData    (oData[c*DATA_W +: DATA_W]),
            .oValid   (oValid[c]),
            .oOverrun (oOverrun[c]),
            .validNext(validNext[c])
        );
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oAnyValid <= 1'b0;
        end else begin
            oAnyValid <= |validNext;
        end
    end

endmodule
